// File: rtl/block_mem_pkg.sv
// Shared types and helpers for the block-memory arbiter between the I- and D-cache fill paths.
package block_mem_pkg;

    localparam int BLOCK_W     = 256;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_FILL = 3'd1;
    localparam logic [2:0] ST_D_WB   = 3'd2;
    localparam logic [2:0] ST_D_FILL = 3'd3;
    localparam logic [2:0] ST_RESP_I = 3'd4;
    localparam logic [2:0] ST_RESP_D = 3'd5;

    typedef enum logic {
        SIDE_D = 1'b0,
        SIDE_I = 1'b1
    } side_e;

    function automatic logic [31:0] blockAlign(input logic [31:0] addr, input int offsetBits);
        return addr & ~((32'h1 << offsetBits) - 32'h1);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter modelling the fixed memory latency; zero marks the last cycle of a memory state.
module mem_latency_counter
    import block_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic load,
    output logic zero
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(MEM_LATENCY - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/block_mem_arbiter.sv
// Arbitrates the single block-memory port between I-side and D-side cache fills,
// writing back a dirty D victim before its fill and stalling the pipeline meanwhile.
module block_mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_W     = block_mem_pkg::BLOCK_W,
    parameter int OFFSET_BITS = block_mem_pkg::OFFSET_BITS
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               IReq_IN,
    input  logic [31:0]        IAddr_IN,
    input  logic               DReq_IN,
    input  logic [31:0]        DAddr_IN,
    input  logic               DDirty_IN,
    input  logic [31:0]        DVictimAddr_IN,
    input  logic [BLOCK_W-1:0] DVictimBlock_IN,
    input  logic [BLOCK_W-1:0] DataBlock_IN,
    output logic               IDone_OUT,
    output logic               DDone_OUT,
    output logic [BLOCK_W-1:0] FillBlock_OUT,
    output logic [31:0]        MemBlockAddress_OUT,
    output logic               MemBlockRead_OUT,
    output logic               MemBlockWrite_OUT,
    output logic [BLOCK_W-1:0] DataBlock_OUT,
    output logic               Stall_OUT
);

    import block_mem_pkg::*;

    logic [2:0]         state;
    side_e              prioPtr;
    logic [31:0]        blockAddr;
    logic [BLOCK_W-1:0] wbData;
    logic [BLOCK_W-1:0] fillData;
    logic               grantD;
    logic               grantI;
    logic               cntLoad;
    logic               cntZero;

    // Requests are only looked at in IDLE; a tie goes to the side the pointer names.
    always_comb begin
        grantD = 1'b0;
        grantI = 1'b0;
        if (state == ST_IDLE) begin
            if (DReq_IN && (!IReq_IN || prioPtr == SIDE_D)) begin
                grantD = 1'b1;
            end else if (IReq_IN) begin
                grantI = 1'b1;
            end
        end
    end

    assign cntLoad = grantD || grantI || (state == ST_D_WB && cntZero);

    mem_latency_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) latencyCounter (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .load (cntLoad),
        .zero (cntZero)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            prioPtr   <= SIDE_D;
            blockAddr <= '0;
            wbData    <= '0;
            fillData  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grantD) begin
                        state     <= DDirty_IN ? ST_D_WB : ST_D_FILL;
                        blockAddr <= blockAlign(DDirty_IN ? DVictimAddr_IN : DAddr_IN, OFFSET_BITS);
                        wbData    <= DVictimBlock_IN;
                        prioPtr   <= SIDE_I;
                    end else if (grantI) begin
                        state     <= ST_I_FILL;
                        blockAddr <= blockAlign(IAddr_IN, OFFSET_BITS);
                        prioPtr   <= SIDE_D;
                    end
                end
                ST_I_FILL: begin
                    if (cntZero) begin
                        fillData <= DataBlock_IN;
                        state    <= ST_RESP_I;
                    end
                end
                // Write-back flows straight into the fill; the fill address is taken here.
                ST_D_WB: begin
                    if (cntZero) begin
                        state     <= ST_D_FILL;
                        blockAddr <= blockAlign(DAddr_IN, OFFSET_BITS);
                    end
                end
                ST_D_FILL: begin
                    if (cntZero) begin
                        fillData <= DataBlock_IN;
                        state    <= ST_RESP_D;
                    end
                end
                ST_RESP_I: state <= ST_IDLE;
                ST_RESP_D: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode the state register so a reset drops them without waiting for a clock.
    assign MemBlockRead_OUT    = (state == ST_I_FILL) || (state == ST_D_FILL);
    assign MemBlockWrite_OUT   = (state == ST_D_WB);
    assign IDone_OUT           = (state == ST_RESP_I);
    assign DDone_OUT           = (state == ST_RESP_D);
    assign MemBlockAddress_OUT = blockAddr;
    assign DataBlock_OUT       = wbData;
    assign FillBlock_OUT       = fillData;
    assign Stall_OUT           = IReq_IN || DReq_IN || (state != ST_IDLE);

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Self-checking bench for block_mem_arbiter with one L=4 and one L=1 instance behind a selector.
module tb_block_mem_arbiter;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic         IReq, DReq, DDirty;
    logic [31:0]  IAddr, DAddr, DVictimAddr;
    logic [255:0] DVictimBlock, DataBlockIn;
    bit           sel;

    always #5 CLOCK = ~CLOCK;

    logic iReq4, dReq4, iReq1, dReq1;
    assign iReq4 = sel ? 1'b0 : IReq;
    assign dReq4 = sel ? 1'b0 : DReq;
    assign iReq1 = sel ? IReq : 1'b0;
    assign dReq1 = sel ? DReq : 1'b0;

    logic         iDone4, dDone4, rd4, wr4, stall4, iDone1, dDone1, rd1, wr1, stall1;
    logic [255:0] fill4, dataOut4, fill1, dataOut1;
    logic [31:0]  addr4, addr1;

    block_mem_arbiter #(.MEM_LATENCY(4), .BLOCK_W(256), .OFFSET_BITS(5)) dut4 (
        .CLOCK(CLOCK), .RESET(RESET),
        .IReq_IN(iReq4), .IAddr_IN(IAddr), .DReq_IN(dReq4), .DAddr_IN(DAddr),
        .DDirty_IN(DDirty), .DVictimAddr_IN(DVictimAddr), .DVictimBlock_IN(DVictimBlock),
        .DataBlock_IN(DataBlockIn), .IDone_OUT(iDone4), .DDone_OUT(dDone4),
        .FillBlock_OUT(fill4), .MemBlockAddress_OUT(addr4), .MemBlockRead_OUT(rd4),
        .MemBlockWrite_OUT(wr4), .DataBlock_OUT(dataOut4), .Stall_OUT(stall4)
    );

    block_mem_arbiter #(.MEM_LATENCY(1), .BLOCK_W(256), .OFFSET_BITS(5)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET),
        .IReq_IN(iReq1), .IAddr_IN(IAddr), .DReq_IN(dReq1), .DAddr_IN(DAddr),
        .DDirty_IN(DDirty), .DVictimAddr_IN(DVictimAddr), .DVictimBlock_IN(DVictimBlock),
        .DataBlock_IN(DataBlockIn), .IDone_OUT(iDone1), .DDone_OUT(dDone1),
        .FillBlock_OUT(fill1), .MemBlockAddress_OUT(addr1), .MemBlockRead_OUT(rd1),
        .MemBlockWrite_OUT(wr1), .DataBlock_OUT(dataOut1), .Stall_OUT(stall1)
    );

    logic         iDoneS, dDoneS, rdS, wrS, stallS;
    logic [255:0] fillS, dataOutS;
    logic [31:0]  addrS;
    assign iDoneS   = sel ? iDone1   : iDone4;
    assign dDoneS   = sel ? dDone1   : dDone4;
    assign rdS      = sel ? rd1      : rd4;
    assign wrS      = sel ? wr1      : wr4;
    assign stallS   = sel ? stall1   : stall4;
    assign fillS    = sel ? fill1    : fill4;
    assign dataOutS = sel ? dataOut1 : dataOut4;
    assign addrS    = sel ? addr1    : addr4;

    typedef struct {
        bit           isD;
        bit           hasWb;
        int           doneCyc;
        int           rdCycles;
        int           wrCycles;
        logic [31:0]  rdAddr;
        logic [31:0]  wrAddr;
        logic [255:0] fill;
        logic [255:0] wbData;
    } exp_t;

    typedef struct {
        bit          sel;
        bit          isD;
        bit          dirty;
        logic [31:0] reqAddr;
        logic [31:0] victimAddr;
        logic [31:0] expRd;
        logic [31:0] expWr;
        int          expDone;
        int          expRdCyc;
        int          expWrCyc;
    } vec_t;

    exp_t         sb[$];
    vec_t         vt[7];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           rdCnt, wrCnt;
    bit           bothSeen, addrMoved, prevRd, prevWr, gotI, gotD;
    logic [31:0]  lastRdAddr, lastWrAddr, prevAddr;
    logic [255:0] lastWrData;

    function automatic logic [255:0] pat(input int n);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = (32'(n) * 32'h9E37_79B9) ^ (32'(i) * 32'h0101_0101) ^ 32'hC3A5_5A3C;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic clearTrack();
        rdCnt = 0; wrCnt = 0; bothSeen = 0; addrMoved = 0;
        prevRd = 0; prevWr = 0; prevAddr = '0;
    endtask

    task automatic push(input bit isD, input bit hasWb, input int doneCyc, input int rdC, input int wrC,
                        input logic [31:0] rdA, input logic [31:0] wrA, input logic [255:0] wbD);
        exp_t e;
        e.isD = isD; e.hasWb = hasWb; e.doneCyc = doneCyc; e.rdCycles = rdC; e.wrCycles = wrC;
        e.rdAddr = rdA; e.wrAddr = wrA; e.fill = pat(doneCyc - 1); e.wbData = wbD;
        sb.push_back(e);
    endtask

    // One clock: advance, drive fresh memory data, observe strobes, score any Done.
    task automatic tick();
        exp_t e;
        @(posedge CLOCK);
        #1;
        cyc++;
        DataBlockIn = pat(cyc);
        gotI = iDoneS;
        gotD = dDoneS;
        if (rdS && wrS) bothSeen = 1;
        if (((rdS && prevRd) || (wrS && prevWr)) && addrS != prevAddr) addrMoved = 1;
        if (rdS) begin rdCnt++; lastRdAddr = addrS; end
        if (wrS) begin wrCnt++; lastWrAddr = addrS; lastWrData = dataOutS; end
        prevRd = rdS; prevWr = wrS; prevAddr = addrS;
        if (iDoneS || dDoneS) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedDone", {iDoneS, dDoneS}, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("doneSide", {iDoneS, dDoneS}, e.isD ? 2'b01 : 2'b10);
                checkOutput("doneCycle", cyc, e.doneCyc);
                checkOutput("fillBlock", fillS, e.fill);
                checkOutput("readAddr", lastRdAddr, e.rdAddr);
                checkOutput("readCycles", rdCnt, e.rdCycles);
                checkOutput("writeCycles", wrCnt, e.wrCycles);
                if (e.hasWb) begin
                    checkOutput("writeAddr", lastWrAddr, e.wrAddr);
                    checkOutput("writeData", lastWrData, e.wbData);
                end
                checkOutput("strobeExclusive", bothSeen, 0);
                checkOutput("addrHeld", addrMoved, 0);
                checkOutput("stallInDone", stallS, 1);
            end
            rdCnt = 0; wrCnt = 0; bothSeen = 0; addrMoved = 0;
        end
    endtask

    // Runs until every queued completion is seen; dKeep D-Dones leave DReq asserted.
    task automatic applyStimulus(input int budget, input int dKeep);
        for (int k = 0; k < budget && sb.size() > 0; k++) begin
            tick();
            if (gotI) IReq = 0;
            if (gotD) begin
                if (dKeep > 0) dKeep--;
                else DReq = 0;
            end
        end
        checkOutput("serveTimeout", sb.size(), 0);
        sb.delete();
        IReq = 0; DReq = 0;
        tick();
        checkOutput("stallIdle", stallS, 0);
        checkOutput("strobesIdle", {rdS, wrS}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        IReq = 0; DReq = 0; DDirty = 0; IAddr = '0; DAddr = '0; DVictimAddr = '0;
        DVictimBlock = '0; DataBlockIn = '0; sel = 0;
        clearTrack();

        //             sel   isD   dirty reqAddr       victimAddr    expRd         expWr       done rd wr
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0040_0024, 32'h0000_0000, 32'h0040_0020, 32'h0,        5, 4, 0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 32'h1000_1044, 32'h1000_0040, 32'h1000_1040, 32'h1000_0040, 9, 4, 4};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h1000_00FF, 32'h0000_0000, 32'h1000_00E0, 32'h0,        5, 4, 0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h2000_003F, 32'h0000_0000, 32'h2000_0020, 32'h0,        2, 1, 0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h3000_0021, 32'h3000_001F, 32'h3000_0020, 32'h3000_0000, 3, 1, 1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFE0, 32'h0,        2, 1, 0};
        vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0,        5, 4, 0};

        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checkOutput("rstRead", rdS, 0);
            checkOutput("rstWrite", wrS, 0);
            checkOutput("rstDone", {iDoneS, dDoneS}, 0);
            checkOutput("rstStall", stallS, 0);
            checkOutput("rstFill", fillS, 0);
            checkOutput("rstAddr", addrS, 0);
            checkOutput("rstDataOut", dataOutS, 0);
        end
        sel = 0;
        @(negedge CLOCK);
        RESET = 1;

        // Tie right after reset: D, then I (pointer moved), then the still-held D again.
        tick();
        DAddr = 32'h1000_2008; DDirty = 0; IAddr = 32'h0040_1010;
        DReq = 1; IReq = 1;
        push(1, 0, cyc + 5,  4, 0, 32'h1000_2000, 32'h0, '0);
        push(0, 0, cyc + 11, 4, 0, 32'h0040_1000, 32'h0, '0);
        push(1, 0, cyc + 17, 4, 0, 32'h1000_2000, 32'h0, '0);
        applyStimulus(80, 1);

        // D request arriving mid I_FILL waits for IDLE.
        tick();
        IAddr = 32'h0040_0104; IReq = 1;
        c0 = cyc;
        push(0, 0, c0 + 5, 4, 0, 32'h0040_0100, 32'h0, '0);
        tick();
        tick();
        DAddr = 32'h2000_0044; DDirty = 0; DReq = 1;
        push(1, 0, c0 + 11, 4, 0, 32'h2000_0040, 32'h0, '0);
        applyStimulus(60, 0);

        for (int i = 0; i < 7; i++) begin
            sel = vt[i].sel;
            tick();
            if (vt[i].isD) begin
                DAddr = vt[i].reqAddr; DVictimAddr = vt[i].victimAddr; DDirty = vt[i].dirty;
                DVictimBlock = pat(1000 + i); DReq = 1;
            end else begin
                IAddr = vt[i].reqAddr; IReq = 1;
            end
            push(vt[i].isD, vt[i].dirty, cyc + vt[i].expDone, vt[i].expRdCyc, vt[i].expWrCyc,
                 vt[i].expRd, vt[i].expWr, pat(1000 + i));
            tick();
            DDirty = ~DDirty; DVictimAddr = 32'hDEAD_BEE0; DVictimBlock = ~DVictimBlock;
            if (!vt[i].isD) IAddr = 32'h0BAD_0000;
            applyStimulus(60, 0);
        end
        sel = 0;

        // Reset in the second write-back cycle aborts; the held DReq then restarts from D_WB.
        tick();
        DDirty = 1; DVictimAddr = 32'h1000_0040; DAddr = 32'h1000_1044;
        DVictimBlock = pat(77); DReq = 1;
        tick();
        tick();
        checkOutput("abortPreWrite", wrS, 1);
        RESET = 0;
        #1;
        checkOutput("abortWrite", wrS, 0);
        checkOutput("abortRead", rdS, 0);
        checkOutput("abortDone", {iDoneS, dDoneS}, 0);
        checkOutput("abortAddr", addrS, 0);
        checkOutput("abortStall", stallS, 1);
        clearTrack();
        @(negedge CLOCK);
        RESET = 1;
        push(1, 1, cyc + 9, 4, 4, 32'h1000_1040, 32'h1000_0040, pat(77));
        applyStimulus(60, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_mem_arbiter.md
Name: block_mem_arbiter

Overview:
- Shares the single block-memory port (MemBlockRead/MemBlockWrite/DataBlock) between the instruction-side and data-side cache-fill requesters of the 5-stage MIPS.
- Sequences dirty-victim write-back before the data fill, models fixed memory latency with a counter, and drives the pipeline-wide stall to the hazard unit.
- Sits between the IF/MEM stage caches and the top-level memory block ports.

Parameters:
MEM_LATENCY, 4, cycles each block read/write stays asserted before completion (legal range 1..15)
BLOCK_W, 256, block width in bits
OFFSET_BITS, 5, byte-offset bits cleared on every block address

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
IReq_IN  in  1  instruction-side fill request, held until IDone_OUT
IAddr_IN  in  32  instruction miss address
DReq_IN  in  1  data-side fill request, held until DDone_OUT
DAddr_IN  in  32  data miss address
DDirty_IN  in  1  victim line dirty, write-back required first
DVictimAddr_IN  in  32  victim line address
DVictimBlock_IN  in  BLOCK_W  victim line data
DataBlock_IN  in  BLOCK_W  block returned by memory
IDone_OUT  out  1  one-cycle pulse, I fill complete
DDone_OUT  out  1  one-cycle pulse, D fill complete
FillBlock_OUT  out  BLOCK_W  registered fill data, valid during Done
MemBlockAddress_OUT  out  32  block-aligned memory address
MemBlockRead_OUT  out  1  block read request
MemBlockWrite_OUT  out  1  block write request
DataBlock_OUT  out  BLOCK_W  write-back data
Stall_OUT  out  1  freeze pipeline

Behaviour:
- Reset (RESET low, async): state IDLE, counter 0, all outputs 0, FillBlock_OUT 0, priority pointer = D.
- States: IDLE, I_FILL, D_WB, D_FILL, RESP_I, RESP_D.
- IDLE arbitration, evaluated only in IDLE:
  - Only DReq high: D_WB if DDirty_IN, else D_FILL.
  - Only IReq high: I_FILL.
  - Both high: grant the side named by the priority pointer.
  - Pointer toggles to the other side after every grant. After reset, D wins the first tie.
- Entering any memory state loads counter = MEM_LATENCY-1.
  - Read or write is asserted every cycle of the state.
  - The counter decrements each cycle; the state completes in the cycle the counter is 0.
- Addresses: MemBlockAddress_OUT = request address with bits [OFFSET_BITS-1:0] forced to 0. It is registered at state entry and held for the whole state.
- D_WB: MemBlockWrite_OUT=1, DataBlock_OUT=DVictimBlock_IN (captured at entry), address=DVictimAddr. On completion go to D_FILL with no idle cycle.
- I_FILL / D_FILL: MemBlockRead_OUT=1. On completion capture DataBlock_IN into FillBlock_OUT and go to RESP_I / RESP_D.
- RESP_x: the matching Done is high for exactly one cycle, then IDLE. Requester must drop Req from the edge ending its Done cycle. A Req still high in IDLE is treated as a new request.
- Latency with MEM_LATENCY=L, from the Req-high edge:
  - Clean fill: Done is high in cycle L+1.
  - Dirty fill: Done is high in cycle 2L+1.
- Stall_OUT = IReq_IN | DReq_IN | (state != IDLE). It is combinational and stays high through the Done cycle.
- Requests arriving mid-operation are not sampled until IDLE; the other side is never preempted.
- DDirty_IN changing after grant has no effect; it is sampled only at arbitration.
- MEM_LATENCY=1: each memory state lasts exactly one cycle.
- RESET asserted mid-operation aborts the transfer immediately. No Done is produced and memory requests drop asynchronously.
- Read and write are never both high. Only one requester is served at a time.

Decomposition:
- Package block_mem_pkg: state enum, BLOCK_W, OFFSET_BITS, block-align function.
- Sub-module mem_latency_counter: load/decrement/zero flag, parameterised by MEM_LATENCY.
- FSM and datapath registers live in block_mem_arbiter.

Test Plan:
- L=4, IReq=1, IAddr=0x0040_0024 -> MemBlockRead high cycles 1-4, address 0x0040_0020, IDone pulse in cycle 5, FillBlock=DataBlock_IN sampled in cycle 4.
- L=4, DReq=1, DDirty=1, victim 0x1000_0040 / DAddr 0x1000_1044 -> write cycles 1-4 @0x1000_0040, read cycles 5-8 @0x1000_1040, DDone in cycle 9, never both strobes high.
- IReq and DReq both rise after reset -> D served first, then I. Repeat with both pending again -> I served first (pointer alternates).
- L=1, clean D fill -> read high in cycle 1 only, DDone in cycle 2, Stall_OUT low in cycle 3 once DReq drops.
- Assert RESET low during D_WB cycle 2 -> all strobes 0 immediately, no DDone, state IDLE. After release, a held DReq restarts from D_WB.
- DReq raised during an I_FILL -> no change in address or strobes until RESP_I/IDLE, then the D transfer starts the following cycle.
